// File: rtl/polaris_dbus_pkg.sv
// Shared definitions for the Polaris D-bus responders: access size codes,
// responder FSM states and the beat count per access size.
package polaris_dbus_pkg;

    localparam logic [1:0] SIZ_B = 2'b00;
    localparam logic [1:0] SIZ_H = 2'b01;
    localparam logic [1:0] SIZ_W = 2'b10;
    localparam logic [1:0] SIZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Halfword beats needed on a 16-bit SRAM for one access of the given size.
    function automatic logic [2:0] beats_for(input logic [1:0] siz);
        case (siz)
            SIZ_W:   return 3'd2;
            SIZ_D:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/polaris_dbus_extend.sv
// Sign/zero extension of right-justified load data to 64 bits by access size.
module polaris_dbus_extend
    import polaris_dbus_pkg::*;
(
    input  logic [1:0]  siz_i,
    input  logic        signed_i,
    input  logic [63:0] dat_i,
    output logic [63:0] dat_o
);

    always_comb begin
        dat_o = dat_i;
        case (siz_i)
            SIZ_B:   dat_o = {{56{signed_i & dat_i[7]}},  dat_i[7:0]};
            SIZ_H:   dat_o = {{48{signed_i & dat_i[15]}}, dat_i[15:0]};
            SIZ_W:   dat_o = {{32{signed_i & dat_i[31]}}, dat_i[31:0]};
            default: dat_o = dat_i;
        endcase
    end

endmodule

// File: rtl/polaris_dbus_sram.sv
// CPU D-port responder: one load/store at a time, split into halfword beats
// on a 16-bit SRAM. States: IDLE | wait for request; BEAT | drive one SRAM
// halfword per WAIT_STATES+1 cycles; ACK | one-cycle dack_o with load data.
module polaris_dbus_sram
    import polaris_dbus_pkg::*;
#(
    parameter int AW          = 20,
    parameter int WAIT_STATES = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          dcyc_i,
    input  logic          dstb_i,
    input  logic          dwe_i,
    input  logic [1:0]    dsiz_i,
    input  logic          dsigned_i,
    input  logic [63:0]   dadr_i,
    input  logic [63:0]   ddat_i,
    output logic [63:0]   ddat_o,
    output logic          dack_o,
    output logic [AW-1:0] sram_adr_o,
    output logic [15:0]   sram_dat_o,
    input  logic [15:0]   sram_dat_i,
    output logic          sram_we_o,
    output logic          sram_oe_o,
    output logic [1:0]    sram_be_o
);

    state_e        state_q, state_d;
    logic          req_we_q, req_we_d;
    logic          req_sgn_q, req_sgn_d;
    logic [1:0]    req_siz_q, req_siz_d;
    logic [AW-1:0] base_q, base_d;
    logic          lane_q, lane_d;
    logic [63:0]   wdat_q, wdat_d;
    logic [1:0]    beat_q, beat_d;
    logic [3:0]    wait_q, wait_d;
    logic [63:0]   asm_q, asm_d;

    logic          dack_q, dack_d;
    logic [63:0]   ddat_q, ddat_d;
    logic [AW-1:0] sram_adr_q, sram_adr_d;
    logic [15:0]   sram_dat_q, sram_dat_d;
    logic          sram_we_q, sram_we_d;
    logic          sram_oe_q, sram_oe_d;
    logic [1:0]    sram_be_q, sram_be_d;

    logic [63:0]   adr_aligned;
    logic [63:0]   asm_merged;
    logic [63:0]   ext_dat;
    logic          unused_adr;

    assign unused_adr = ^{adr_aligned[63:AW+1], adr_aligned[0]};

    always_comb begin
        adr_aligned = dadr_i;
        case (dsiz_i)
            SIZ_H:   adr_aligned[0]   = 1'b0;
            SIZ_W:   adr_aligned[1:0] = 2'b00;
            SIZ_D:   adr_aligned[2:0] = 3'b000;
            default: adr_aligned      = dadr_i;
        endcase
    end

    // Current beat's SRAM read data merged into the assembly register.
    always_comb begin
        asm_merged = asm_q;
        if (req_siz_q == SIZ_B) begin
            asm_merged[7:0] = lane_q ? sram_dat_i[15:8] : sram_dat_i[7:0];
        end else begin
            asm_merged[{beat_q, 4'b0000} +: 16] = sram_dat_i;
        end
    end

    polaris_dbus_extend u_extend (
        .siz_i    (req_siz_q),
        .signed_i (req_sgn_q),
        .dat_i    (asm_merged),
        .dat_o    (ext_dat)
    );

    always_comb begin
        state_d   = state_q;
        req_we_d  = req_we_q;
        req_sgn_d = req_sgn_q;
        req_siz_d = req_siz_q;
        base_d    = base_q;
        lane_d    = lane_q;
        wdat_d    = wdat_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        asm_d     = asm_q;
        dack_d    = 1'b0;
        ddat_d    = 64'd0;

        case (state_q)
            IDLE: begin
                if (dcyc_i && dstb_i) begin
                    req_we_d  = dwe_i;
                    req_sgn_d = dsigned_i;
                    req_siz_d = dsiz_i;
                    base_d    = adr_aligned[AW:1];
                    lane_d    = dadr_i[0];
                    wdat_d    = ddat_i;
                    beat_d    = 2'd0;
                    wait_d    = 4'd0;
                    asm_d     = 64'd0;
                    state_d   = BEAT;
                end
            end
            BEAT: begin
                if (!dcyc_i) begin
                    state_d = IDLE;
                end else if (wait_q == 4'(WAIT_STATES)) begin
                    wait_d = 4'd0;
                    asm_d  = asm_merged;
                    if ({1'b0, beat_q} == beats_for(req_siz_q) - 3'd1) begin
                        state_d = ACK;
                        dack_d  = 1'b1;
                        ddat_d  = req_we_q ? 64'd0 : ext_dat;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // SRAM pins are registered from the next-cycle beat so they change on the edge.
        sram_adr_d = '0;
        sram_dat_d = 16'd0;
        sram_be_d  = 2'b00;
        sram_we_d  = 1'b0;
        sram_oe_d  = 1'b0;
        if (state_d == BEAT) begin
            sram_adr_d = base_d + AW'(beat_d);
            sram_be_d  = (req_siz_d == SIZ_B) ? (lane_d ? 2'b10 : 2'b01) : 2'b11;
            sram_we_d  = req_we_d;
            sram_oe_d  = !req_we_d;
            if (req_we_d) begin
                sram_dat_d = (req_siz_d == SIZ_B) ? {2{wdat_d[7:0]}}
                                                  : wdat_d[{beat_d, 4'b0000} +: 16];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            req_we_q   <= 1'b0;
            req_sgn_q  <= 1'b0;
            req_siz_q  <= 2'b00;
            base_q     <= '0;
            lane_q     <= 1'b0;
            wdat_q     <= 64'd0;
            beat_q     <= 2'd0;
            wait_q     <= 4'd0;
            asm_q      <= 64'd0;
            dack_q     <= 1'b0;
            ddat_q     <= 64'd0;
            sram_adr_q <= '0;
            sram_dat_q <= 16'd0;
            sram_we_q  <= 1'b0;
            sram_oe_q  <= 1'b0;
            sram_be_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            req_we_q   <= req_we_d;
            req_sgn_q  <= req_sgn_d;
            req_siz_q  <= req_siz_d;
            base_q     <= base_d;
            lane_q     <= lane_d;
            wdat_q     <= wdat_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            asm_q      <= asm_d;
            dack_q     <= dack_d;
            ddat_q     <= ddat_d;
            sram_adr_q <= sram_adr_d;
            sram_dat_q <= sram_dat_d;
            sram_we_q  <= sram_we_d;
            sram_oe_q  <= sram_oe_d;
            sram_be_q  <= sram_be_d;
        end
    end

    assign dack_o     = dack_q;
    assign ddat_o     = ddat_q;
    assign sram_adr_o = sram_adr_q;
    assign sram_dat_o = sram_dat_q;
    assign sram_we_o  = sram_we_q;
    assign sram_oe_o  = sram_oe_q;
    assign sram_be_o  = sram_be_q;

endmodule

// File: tb/tb_polaris_dbus_sram.sv
// Bench for polaris_dbus_sram: directed scenarios plus random loads/stores
// against a byte-addressed memory model.
module tb_polaris_dbus_sram;

    localparam int AW = 20;
    localparam int BL = 2;  // WAIT_STATES=1 -> two cycles per beat

    logic          clk_i = 1'b0;
    logic          reset_i, dcyc_i, dstb_i, dwe_i, dsigned_i;
    logic [1:0]    dsiz_i;
    logic [63:0]   dadr_i, ddat_i, ddat_o;
    logic          dack_o;
    logic [AW-1:0] sram_adr_o;
    logic [15:0]   sram_dat_o, sram_dat_i;
    logic          sram_we_o, sram_oe_o;
    logic [1:0]    sram_be_o;

    logic [15:0]   sram    [0:(1<<AW)-1];
    logic [7:0]    ref_mem [0:(1<<(AW+1))-1];

    int checks = 0;
    int errors = 0;

    logic          nx_we, nx_sgn, rq_we, rq_sgn;
    logic [1:0]    nx_siz, rq_siz;
    logic [63:0]   nx_adr, nx_dat, rq_adr, rq_dat;
    logic [63:0]   got;
    logic          seen;

    polaris_dbus_sram #(.AW(AW), .WAIT_STATES(1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .dcyc_i(dcyc_i), .dstb_i(dstb_i),
        .dwe_i(dwe_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i), .dadr_i(dadr_i),
        .ddat_i(ddat_i), .ddat_o(ddat_o), .dack_o(dack_o), .sram_adr_o(sram_adr_o),
        .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i), .sram_we_o(sram_we_o),
        .sram_oe_o(sram_oe_o), .sram_be_o(sram_be_o)
    );

    always #5 clk_i = ~clk_i;

    assign sram_dat_i = sram_oe_o ? sram[sram_adr_o] : 16'hDEAD;

    always @(posedge clk_i) begin
        if (sram_we_o) begin
            if (sram_be_o[0]) sram[sram_adr_o][7:0]  = sram_dat_o[7:0];
            if (sram_be_o[1]) sram[sram_adr_o][15:8] = sram_dat_o[15:8];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got_v, exp_v);
        end
    endtask

    task automatic set_hw(input int a, input logic [15:0] v);
        sram[a]          = v;
        ref_mem[2*a]     = v[7:0];
        ref_mem[2*a + 1] = v[15:8];
    endtask

    function automatic logic [63:0] model_load(input logic [1:0] siz, input logic sgn,
                                               input logic [63:0] adr);
        int          n;
        logic [63:0] al, v;
        logic [20:0] bi;
        n  = 1 << siz;
        al = adr & ~64'(n - 1);
        v  = 64'd0;
        for (int i = 0; i < n; i++) begin
            bi = al[20:0] + 21'(i);
            v  = v | (64'(ref_mem[bi]) << (8 * i));
        end
        if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] siz, input logic [63:0] adr,
                               input logic [63:0] dat);
        int          n;
        logic [63:0] al;
        logic [20:0] bi;
        n  = 1 << siz;
        al = adr & ~64'(n - 1);
        for (int i = 0; i < n; i++) begin
            bi          = al[20:0] + 21'(i);
            ref_mem[bi] = 8'(dat >> (8 * i));
        end
    endtask

    task automatic gen_nx();
        nx_we  = 1'($urandom);
        nx_sgn = 1'($urandom);
        nx_siz = 2'($urandom);
        nx_dat = {$urandom(), $urandom()};
        nx_adr = {$urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) nx_adr[20:0] = 21'h1FFFC0 | 21'($urandom_range(0, 63));
        else                           nx_adr[20:0] = 21'($urandom_range(0, 127));
    endtask

    task automatic drive_nx();
        rq_we = nx_we; rq_sgn = nx_sgn; rq_siz = nx_siz; rq_adr = nx_adr; rq_dat = nx_dat;
        dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = nx_we; dsigned_i = nx_sgn;
        dsiz_i = nx_siz; dadr_i = nx_adr; ddat_i = nx_dat;
    endtask

    task automatic set_nx(input logic we, input logic [1:0] siz, input logic sgn,
                          input logic [63:0] adr, input logic [63:0] dat);
        nx_we = we; nx_siz = siz; nx_sgn = sgn; nx_adr = adr; nx_dat = dat;
    endtask

    // Request is on the inputs; checks every cycle from capture through ACK to IDLE.
    task automatic run_check(input bit chain, output logic [63:0] ack_dat);
        logic          we, sgn;
        logic [1:0]    siz, eb;
        logic [63:0]   adr, dat, al, exp_d;
        logic [AW-1:0] ea;
        logic [15:0]   ed;
        int            n, nb, lat, k;
        we = rq_we; sgn = rq_sgn; siz = rq_siz; adr = rq_adr; dat = rq_dat;
        n     = 1 << siz;
        nb    = (n + 1) / 2;
        lat   = 1 + nb * BL;
        al    = adr & ~64'(n - 1);
        exp_d = we ? 64'd0 : model_load(siz, sgn, adr);
        ack_dat = 64'd0;
        @(posedge clk_i);
        for (int c = 1; c <= lat; c++) begin
            #1;
            if (c == 1) begin
                dstb_i = 1'($urandom); dwe_i = 1'($urandom); dsigned_i = 1'($urandom);
                dsiz_i = 2'($urandom); dadr_i = {$urandom(), $urandom()};
                ddat_i = {$urandom(), $urandom()};
            end
            if (c < lat) begin
                k  = (c - 1) / BL;
                ea = AW'((al >> 1) + 64'(k));
                eb = (n == 1) ? (adr[0] ? 2'b10 : 2'b01) : 2'b11;
                ed = (n == 1) ? {dat[7:0], dat[7:0]} : 16'(dat >> (16 * k));
                chk("beat_adr", 64'(sram_adr_o), 64'(ea));
                chk("beat_be", 64'(sram_be_o), 64'(eb));
                chk("beat_we_oe", 64'({sram_we_o, sram_oe_o}), 64'({we, !we}));
                if (we) chk("beat_wdat", 64'(sram_dat_o), 64'(ed));
                chk("beat_dack", 64'(dack_o), 64'd0);
            end else begin
                chk("ack_dack", 64'(dack_o), 64'd1);
                chk("ack_ddat", ddat_o, exp_d);
                chk("ack_strobes", 64'({sram_we_o, sram_oe_o}), 64'd0);
                ack_dat = ddat_o;
                if (chain) drive_nx();
                else       dstb_i = 1'b0;
            end
            @(posedge clk_i);
        end
        #1;
        chk("idle_dack", 64'(dack_o), 64'd0);
        chk("idle_ddat", ddat_o, 64'd0);
        chk("idle_strobes", 64'({sram_we_o, sram_oe_o}), 64'd0);
        if (we) model_store(siz, adr, dat);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) set_hw(i, 16'($urandom));
        reset_i = 1'b1; dcyc_i = 1'b0; dstb_i = 1'b0; dwe_i = 1'b0; dsigned_i = 1'b0;
        dsiz_i = 2'b00; dadr_i = 64'd0; ddat_i = 64'd0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_dack", 64'(dack_o), 64'd0);
        chk("rst_ddat", ddat_o, 64'd0);
        chk("rst_strobes", 64'({sram_we_o, sram_oe_o, sram_be_o}), 64'd0);
        chk("rst_adr_dat", {28'd0, sram_adr_o, sram_dat_o}, 64'd0);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        set_hw(1, 16'h80AB);
        set_nx(1'b0, 2'b00, 1'b1, 64'h3, 64'd0); drive_nx();
        run_check(1'b0, got);
        chk("tp_sbyte", got, 64'hFFFF_FFFF_FFFF_FF80);

        set_nx(1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788); drive_nx();
        run_check(1'b0, got);
        chk("tp_dst_ddat", got, 64'd0);
        chk("tp_dst_mem8", 64'(sram[8]), 64'h7788);
        chk("tp_dst_mem11", 64'(sram[11]), 64'h1122);

        set_hw(16, 16'h0000); set_hw(17, 16'h8000);
        set_nx(1'b0, 2'b10, 1'b0, 64'h20, 64'd0); drive_nx();
        run_check(1'b0, got);
        chk("tp_uword", got, 64'h0000_0000_8000_0000);
        set_nx(1'b0, 2'b10, 1'b1, 64'h20, 64'd0); drive_nx();
        run_check(1'b0, got);
        chk("tp_sword", got, 64'hFFFF_FFFF_8000_0000);

        set_hw(2, 16'h1234);
        set_nx(1'b1, 2'b00, 1'b0, 64'h5, 64'hAB); drive_nx();
        run_check(1'b0, got);
        chk("tp_bst_mem", 64'(sram[2]), 64'hAB34);

        set_nx(1'b0, 2'b11, 1'b0, 64'h0, 64'd0); drive_nx();
        @(posedge clk_i); #1;
        dstb_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mid_oe", 64'(sram_oe_o), 64'd1);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_mid_strobes", 64'({sram_we_o, sram_oe_o, sram_be_o}), 64'd0);
        chk("rst_mid_dack", 64'(dack_o), 64'd0);
        reset_i = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(posedge clk_i); #1; if (dack_o) seen = 1'b1; end
        chk("rst_no_ack", 64'(seen), 64'd0);
        set_nx(1'b0, 2'b01, 1'b0, 64'h22, 64'd0); drive_nx();
        run_check(1'b0, got);

        set_nx(1'b0, 2'b10, 1'b0, 64'h8, 64'd0); drive_nx();
        set_nx(1'b0, 2'b11, 1'b0, 64'h40, 64'd0);
        run_check(1'b1, got);
        run_check(1'b0, got);

        set_nx(1'b0, 2'b10, 1'b0, 64'h30, 64'd0); drive_nx();
        @(posedge clk_i); #1;
        dstb_i = 1'b0;
        chk("abort_c1_oe", 64'(sram_oe_o), 64'd1);
        @(posedge clk_i); #1;
        dcyc_i = 1'b0;
        @(posedge clk_i); #1;
        chk("abort_strobes", 64'({sram_we_o, sram_oe_o}), 64'd0);
        seen = 1'b0;
        repeat (6) begin @(posedge clk_i); #1; if (dack_o) seen = 1'b1; end
        chk("abort_no_ack", 64'(seen), 64'd0);

        for (int t = 0; t < 80; t++) begin
            gen_nx(); drive_nx();
            if ($urandom_range(0, 2) == 0) begin
                gen_nx();
                run_check(1'b1, got);
            end
            run_check(1'b0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
